lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit between the execute result and the data bus.
- Takes the ALU-computed address and rs2 store data, and runs one bus transaction per memory instruction with a req/ack handshake.
- Holds the core via `stall` while the transaction is in progress.
- Returns the byte-aligned, sign/zero-extended load value on `data_out`, the memory input of the writeback source mux.

Parameters:
- TIMEOUT, 255, bus wait-cycle limit before the access is aborted with `fault`; 0 disables the timeout.
- TW, 8, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_req  in  1  current instruction is a load or store; held stable while `stall`=1.
- mem_we  in  1  1=store, 0=load.
- funct3  in  3  RV32I width/sign field.
- addr  in  32  byte address (ALU result).
- store_data  in  32  rs2 value.
- data_out  out  32  extended load data; valid in DONE, held until the next load completes.
- stall  out  1  core must not advance.
- fault  out  1  misaligned, illegal funct3, or timeout; valid in DONE.
- bus_req  out  1  transaction request.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word address, bits[1:0]=0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data, valid with `bus_ack`.
- bus_ack  in  1  transaction complete, sampled while `bus_req`=1.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: state IDLE; `data_out`, `fault`, `bus_req`, `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` all 0; `stall` forced 0 while `rst_n`=0.
- Reset mid-transaction: state returns to IDLE and `bus_req` drops at that edge. A late `bus_ack` after reset is ignored.
- FSM states: IDLE, BUS, DONE.
- stall (combinational) = (IDLE & `mem_req`) | BUS.
- IDLE, `mem_req`=0: stay in IDLE.
- IDLE, `mem_req`=1, access legal: register `bus_addr`/`bus_be`/`bus_wdata`/`bus_we`, set `bus_req`=1, clear the timeout counter, go to BUS.
- IDLE, `mem_req`=1, access illegal: no bus access; `fault`<=1, `data_out` unchanged, go to DONE.
- BUS, `bus_ack`=1: `bus_req`<=0. For a load, `data_out`<=extended `bus_rdata`. `fault`<=0. Go to DONE.
- BUS, no ack, counter==TIMEOUT (TIMEOUT≠0): `bus_req`<=0, `fault`<=1, go to DONE. Otherwise increment the counter.
- DONE: `stall`=0 so the core retires the instruction. Go to IDLE unconditionally. `mem_req` still high in DONE is never re-accepted.
- Illegal access:
  - funct3 ∈ {011, 110, 111}; stores additionally reject 100 and 101.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
- Byte enables:
  - B: 1<<addr[1:0].
  - H: 0011 or 1100 by addr[1].
  - W: 1111.
- Store data: SB replicates the byte x4, SH replicates the halfword x2, SW passes through.
- Load extraction: select the lane by addr[1:0]. LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes through.
- Latency, ack in the first BUS cycle: IDLE(stall) → BUS → DONE, 3 cycles. Each extra wait cycle adds 1.
- `bus_ack` outside BUS is ignored.

Decomposition:
- Shared package `riscv_pkg` holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - LSU state encoding (2 bits).
- Sub-module `load_align`: combinational lane select and extend, driven by (rdata, addr[1:0], funct3) → 32-bit value. Instantiated once.

Test Plan:
- LB, addr=0x1003, `bus_rdata`=0x80FF_1234, ack on first BUS cycle → `bus_be`=1000, `bus_addr`=0x1000; `data_out`=0xFFFF_FF80 in DONE; `stall` high for exactly 2 cycles.
- SH, addr=0x2002, `store_data`=0x0000_BEEF → `bus_be`=1100, `bus_wdata`=0xBEEF_BEEF, `bus_we`=1; with ack after 3 wait cycles, `stall` is high for 5 cycles and `fault`=0.
- LW, addr=0x3001 → no `bus_req` pulse; DONE next cycle with `fault`=1; `data_out` keeps its prior value.
- LHU, addr=0x0002, `bus_rdata`=0xF00D_0000 → `data_out`=0x0000_F00D. LH of the same data → `data_out`=0xFFFF_F00D.
- TIMEOUT=4, `bus_ack` never asserted → `bus_req` drops after 5 BUS cycles, `fault`=1, FSM returns to IDLE.
- `rst_n`=0 for one cycle while in BUS → next cycle IDLE with `bus_req`=0, `data_out`=0; an ack arriving afterwards has no effect.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state encoding
// and the access-legality / lane helpers used by the load/store unit.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Unsigned widths only make sense for loads; sizes must be naturally aligned.
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = ~we;
      F3_H:    ok = ~off[0];
      F3_HU:   ok = ~we & ~off[0];
      F3_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_B, F3_BU: w = {4{d[7:0]}};
      F3_H, F3_HU: w = {2{d[15:0]}};
      default:     w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and extension: picks the addressed byte/halfword out of the
// bus word and sign- or zero-extends it according to funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_value = i_rdata;
    case (i_funct3)
      F3_B:    o_value = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_value = {24'h000000, w_byte};
      F3_H:    o_value = {{16{w_half[15]}}, w_half};
      F3_HU:   o_value = {16'h0000, w_half};
      default: o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/ack bus transaction per memory instruction, stalls
// the core while it is outstanding and returns the extended load value.
module lsu
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] data_out,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  lsu_state_e    r_state;
  lsu_state_e    w_next_state;
  logic [TW-1:0] r_cnt;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;
  logic          w_legal;
  logic          w_timeout;
  logic [31:0]   w_load;

  assign w_legal   = access_legal(mem_we, funct3, addr[1:0]);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TW'(TIMEOUT));
  assign stall     = rst_n & (((r_state == ST_IDLE) & mem_req) | (r_state == ST_BUS));

  load_align u_load_align (
    .i_rdata  (bus_rdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_value  (w_load)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // DONE is a single retire cycle; it never samples mem_req.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_req) w_next_state = w_legal ? ST_BUS : ST_DONE;
        else         w_next_state = ST_IDLE;
      end
      ST_BUS: begin
        if (bus_ack || w_timeout) w_next_state = ST_DONE;
        else                      w_next_state = ST_BUS;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out  <= 32'h0000_0000;
      fault     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0000_0000;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0000_0000;
      r_cnt     <= '0;
      r_funct3  <= 3'b000;
      r_off     <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_req && w_legal) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= byte_enables(funct3, addr[1:0]);
            bus_wdata <= store_lanes(funct3, store_data);
            r_cnt     <= '0;
            r_funct3  <= funct3;
            r_off     <= addr[1:0];
          end else if (mem_req) begin
            fault <= 1'b1;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            fault   <= 1'b0;
            if (!bus_we) data_out <= w_load;
          end else if (w_timeout) begin
            bus_req <= 1'b0;
            fault   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a transaction-level model tracks every output
// cycle by cycle, with literal expectations from the directed scenarios.
module tb_lsu;

  localparam int TO = 4;
  localparam logic [2:0] C_LB  = 3'b000;
  localparam logic [2:0] C_LH  = 3'b001;
  localparam logic [2:0] C_LW  = 3'b010;
  localparam logic [2:0] C_LBU = 3'b100;
  localparam logic [2:0] C_LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n, mem_req, mem_we, bus_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, bus_rdata;
  logic [31:0] data_out, bus_addr, bus_wdata;
  logic        stall, fault, bus_req, bus_we;
  logic [3:0]  bus_be;

  int n_chk = 0;
  int n_pass = 0;
  int stall_total = 0;
  int st;
  bit chk_en = 1'b0;

  logic        e_stall, e_req, e_we, e_fault;
  logic [31:0] e_addr, e_wdata, e_dout;
  logic [3:0]  e_be;

  lsu #(.TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
    .addr(addr), .store_data(store_data), .data_out(data_out), .stall(stall),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  function automatic int width_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int w;
    w = width_of(f3);
    if (w == 0) return 1'b0;
    if (we && f3[2]) return 1'b0;
    return (int'(a[1:0]) % w) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int w;
    w = width_of(f3);
    return 4'(((1 << w) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int w;
    w = width_of(f3);
    if (w == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
    else if (w == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
    else return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    int w;
    w = width_of(f3);
    v = rd >> (8 * int'(a[1:0]));
    if (w == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (w == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, want %08h", name, act, exp);
  endtask

  task automatic compare_all();
    if (stall === 1'b1) stall_total++;
    chk("stall",     32'(stall),   32'(e_stall));
    chk("bus_req",   32'(bus_req), 32'(e_req));
    chk("bus_we",    32'(bus_we),  32'(e_we));
    chk("fault",     32'(fault),   32'(e_fault));
    chk("bus_addr",  bus_addr,     e_addr);
    chk("bus_be",    32'(bus_be),  32'(e_be));
    chk("bus_wdata", bus_wdata,    e_wdata);
    chk("data_out",  data_out,     e_dout);
  endtask

  // One instruction: present it, answer the bus after nwait wait cycles (or never).
  task automatic run(input bit we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rd, input int nwait,
                     input bit ack_ever, output int stalls);
    int start;
    bit ok;
    start = stall_total;
    ok = legal(we, f3, a);
    mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; store_data = sd;
    bus_rdata = rd; bus_ack = 1'b0;
    e_stall = 1'b1;
    @(posedge clk); #1;
    if (!ok) begin
      e_fault = 1'b1;
      e_stall = 1'b0;
    end else begin
      e_req = 1'b1; e_we = we; e_addr = {a[31:2], 2'b00};
      e_be = m_be(f3, a); e_wdata = m_wdata(f3, sd);
      for (int k = 0; k <= TO; k++) begin
        bus_ack = ack_ever && (k == nwait);
        @(posedge clk); #1;
        if (bus_ack) begin
          bus_ack = 1'b0;
          e_req = 1'b0; e_fault = 1'b0; e_stall = 1'b0;
          if (!we) e_dout = m_load(f3, a, rd);
          break;
        end else if (k == TO) begin
          e_req = 1'b0; e_fault = 1'b1; e_stall = 1'b0;
        end
      end
    end
    // mem_req stays high through DONE; it must not start a second access.
    @(posedge clk); #1;
    mem_req = 1'b0;
    stalls = stall_total - start;
  endtask

  initial begin
    rst_n = 1'b0; mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_fault = 1'b0;
    e_addr = 32'h0; e_wdata = 32'h0; e_dout = 32'h0; e_be = 4'h0;
    fork
      forever begin
        @(negedge clk);
        if (chk_en) compare_all();
      end
    join_none
    @(posedge clk); #1; chk_en = 1'b1;
    @(posedge clk); #1; mem_req = 1'b0; rst_n = 1'b1;
    chk("rst_dout", data_out, 32'h0);

    run(1'b0, C_LB, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1'b1, st);
    chk("lb_stalls", 32'(st), 32'd2);
    chk("lb_be", 32'(bus_be), 32'h8);
    chk("lb_addr", bus_addr, 32'h0000_1000);
    chk("lb_dout", data_out, 32'hFFFF_FF80);

    run(1'b1, C_LH, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 3, 1'b1, st);
    chk("sh_stalls", 32'(st), 32'd5);
    chk("sh_be", 32'(bus_be), 32'hC);
    chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    chk("sh_we", 32'(bus_we), 32'd1);
    chk("sh_fault", 32'(fault), 32'd0);

    run(1'b0, C_LW, 32'h0000_3001, 32'h0, 32'h1234_5678, 0, 1'b1, st);
    chk("lw_mis_stalls", 32'(st), 32'd1);
    chk("lw_mis_fault", 32'(fault), 32'd1);
    chk("lw_mis_dout", data_out, 32'hFFFF_FF80);

    run(1'b0, C_LHU, 32'h0000_0002, 32'h0, 32'hF00D_0000, 1, 1'b1, st);
    chk("lhu_dout", data_out, 32'h0000_F00D);
    run(1'b0, C_LH, 32'h0000_0002, 32'h0, 32'hF00D_0000, 0, 1'b1, st);
    chk("lh_dout", data_out, 32'hFFFF_F00D);

    run(1'b0, C_LW, 32'h0000_0040, 32'h0, 32'h0, 0, 1'b0, st);
    chk("to_stalls", 32'(st), 32'(TO + 2));
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_req", 32'(bus_req), 32'd0);

    run(1'b1, C_LB, 32'h0000_5001, 32'h1234_5678, 32'h0, 0, 1'b1, st);
    chk("sb_be", 32'(bus_be), 32'h2);
    chk("sb_wdata", bus_wdata, 32'h7878_7878);
    run(1'b0, C_LBU, 32'h0000_5002, 32'h0, 32'h00AB_0000, 2, 1'b1, st);
    chk("lbu_dout", data_out, 32'h0000_00AB);
    run(1'b1, C_LW, 32'h0000_6000, 32'hCAFE_F00D, 32'h0, 1, 1'b1, st);
    chk("sw_wdata", bus_wdata, 32'hCAFE_F00D);
    run(1'b1, C_LBU, 32'h0000_6004, 32'h0, 32'h0, 0, 1'b1, st);
    chk("sbu_fault", 32'(fault), 32'd1);
    run(1'b0, 3'b011, 32'h0000_6008, 32'h0, 32'h0, 0, 1'b1, st);
    chk("f3_011_fault", 32'(fault), 32'd1);
    run(1'b1, C_LH, 32'h0000_2001, 32'h0, 32'h0, 0, 1'b1, st);
    chk("sh_mis_fault", 32'(fault), 32'd1);

    // Reset for one cycle while a load waits on the bus, then a late ack.
    mem_req = 1'b1; mem_we = 1'b0; funct3 = C_LW; addr = 32'h0000_0100;
    store_data = 32'h1111_2222; bus_rdata = 32'hDEAD_BEEF; bus_ack = 1'b0;
    e_stall = 1'b1;
    @(posedge clk); #1;
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h0000_0100; e_be = 4'hF;
    e_wdata = m_wdata(C_LW, store_data);
    rst_n = 1'b0; e_stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_req = 1'b0; bus_ack = 1'b1;
    e_req = 1'b0; e_we = 1'b0; e_fault = 1'b0; e_addr = 32'h0;
    e_wdata = 32'h0; e_dout = 32'h0; e_be = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("rst_mid_req", 32'(bus_req), 32'd0);
    chk("rst_mid_dout", data_out, 32'h0);

    run(1'b0, C_LB, 32'h0000_7000, 32'h0, 32'h0000_007F, 0, 1'b1, st);
    chk("post_rst_dout", data_out, 32'h0000_007F);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
